// File: rtl/pmem_loader_pkg.sv
// pmem_loader_pkg
//   Shared definitions for the program-memory loader:
//   - 3-bit state encoding of the loader FSM
//   - default halfword address width, sized to the program-memory depth
//   - header field order of the incoming byte stream
package pmem_loader_pkg;

    // Program memory holds 2**10 = 1024 halfwords.
    localparam int PMEM_ADDR_WIDTH = 10;

    // Header precedes the image: halfword count, little-endian.
    typedef enum logic [0:0] {
        HDR_LEN_LO = 1'b0,
        HDR_LEN_HI = 1'b1
    } hdr_field_e;

    localparam int HDR_BYTES = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN_LO  = 3'd1;
    localparam logic [2:0] ST_LEN_HI  = 3'd2;
    localparam logic [2:0] ST_DATA_LO = 3'd3;
    localparam logic [2:0] ST_DATA_HI = 3'd4;
    localparam logic [2:0] ST_CSUM    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_ERROR   = 3'd7;

endpackage

// File: rtl/pmem_loader.sv
// pmem_loader
//   Writer side of the halfword program memory. Receives a byte stream
//   (LEN_LO, LEN_HI, 2N data bytes low byte first, CSUM), writes one
//   halfword per data pair and holds the core in reset until the image
//   has been written and its mod-256 byte sum matches CSUM.
//
// Ports
//   clock, reset          clock, asynchronous active-high reset
//   start                 begin a load (honoured in IDLE, DONE, ERROR)
//   byte_valid/byte_data  incoming stream byte
//   byte_ready            loader accepts a byte (decode of state only)
//   wr_en/wr_addr/wr_data program-memory write port, one strobe per halfword
//   cpu_reset             core reset, low only once a load verified
//   done, error           load verified / load aborted
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_LO  | waiting for low byte of halfword count
// LEN_HI  | waiting for high byte of halfword count, range check
// DATA_LO | waiting for low byte of next halfword
// DATA_HI | waiting for high byte, issues the memory write
// CSUM    | waiting for checksum byte
// DONE    | image verified, core released
// ERROR   | bad length or checksum, core held in reset
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = PMEM_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    // Full 2**ADDR_WIDTH image is legal, so count/index carry one extra bit.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    logic [2:0]          state;
    logic [7:0]          len_lo;
    logic [7:0]          data_lo;
    logic [7:0]          sum;
    logic [ADDR_WIDTH:0] len;
    logic [ADDR_WIDTH:0] index;
    logic [ADDR_WIDTH:0] index_inc;
    logic [15:0]         len_full;
    logic                xfer;

    assign byte_ready = (state == ST_LEN_LO)  || (state == ST_LEN_HI) ||
                        (state == ST_DATA_LO) || (state == ST_DATA_HI) ||
                        (state == ST_CSUM);
    assign xfer       = byte_valid && byte_ready;
    assign len_full   = {byte_data, len_lo};
    assign index_inc  = index + (ADDR_WIDTH+1)'(1);

    assign cpu_reset  = (state != ST_DONE);
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            len_lo  <= '0;
            data_lo <= '0;
            sum     <= '0;
            len     <= '0;
            index   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_LEN_LO;
                end
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state  <= ST_LEN_LO;
                        len_lo <= '0;
                        len    <= '0;
                        index  <= '0;
                        sum    <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= byte_data;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len   <= len_full[ADDR_WIDTH:0];
                        index <= '0;
                        sum   <= '0;
                        if ({1'b0, len_full} > MAX_LEN)
                            state <= ST_ERROR;
                        else if (len_full == 16'd0)
                            state <= ST_CSUM;
                        else
                            state <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (xfer) begin
                        data_lo <= byte_data;
                        sum     <= sum + byte_data;
                        state   <= ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    if (xfer) begin
                        sum     <= sum + byte_data;
                        wr_en   <= 1'b1;
                        wr_addr <= index[ADDR_WIDTH-1:0];
                        wr_data <= {byte_data, data_lo};
                        index   <= index_inc;
                        state   <= (index_inc == len) ? ST_CSUM : ST_DATA_LO;
                    end
                end
                ST_CSUM: begin
                    if (xfer) state <= (byte_data == sum) ? ST_DONE : ST_ERROR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_loader.sv
// tb_pmem_loader
//   Self-checking bench for pmem_loader: a table of load scenarios driven
//   through a byte-stream task, expected writes queued on a scoreboard and
//   popped by a write monitor, plus hand-written length-overflow and
//   asynchronous-reset sequences.
module tb_pmem_loader;
    import pmem_loader_pkg::*;

    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          cpu_reset;
    logic          done;
    logic          error;

    pmem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    logic [AW-1:0] last_addr = '0;
    logic [AW+15:0] sb[$];

    typedef struct {
        int n;
        bit fixed;
        bit bad_csum;
        bit gaps;
        bit mid_start;
        bit exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued halfword.
    always @(negedge clock) begin
        if (!reset && wr_en) begin
            writes_seen++;
            last_addr = wr_addr;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_wr_en: addr 0x%0h data 0x%0h with nothing expected", wr_addr, wr_data);
            end else begin
                logic [AW+15:0] exp;
                exp = sb.pop_front();
                if ({wr_addr, wr_data} !== exp) begin
                    errors++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             wr_addr, wr_data, exp[AW+15:16], exp[15:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
        int k;
        int cnt;
        if (gaps) begin
            k = $urandom_range(0, 3);
            repeat (k) begin
                @(negedge clock);
                byte_valid = 1'b0;
                @(posedge clock);
            end
        end
        @(negedge clock);
        byte_valid = 1'b1;
        byte_data  = b;
        start      = with_start;
        cnt = 0;
        while (!byte_ready && cnt < 8) begin
            @(posedge clock);
            @(negedge clock);
            cnt++;
        end
        checks++;
        if (!byte_ready) begin
            errors++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic run_load(input vec_t v, input int idx);
        logic [15:0] hw;
        logic [7:0]  csum;
        csum = 8'h00;
        writes_seen = 0;
        pulse_start();
        check($sformatf("v%0d cpu_reset_at_start", idx), cpu_reset, 1);
        check($sformatf("v%0d done_at_start", idx), done, 0);
        send_byte(v.n[7:0], v.gaps, 1'b0);
        send_byte(v.n[15:8], v.gaps, 1'b0);
        for (int i = 0; i < v.n; i++) begin
            if (v.fixed) hw = (i == 0) ? 16'h0513 : 16'h4585;
            else         hw = 16'($urandom);
            csum = csum + hw[7:0] + hw[15:8];
            send_byte(hw[7:0], v.gaps, v.mid_start && (i == 0));
            sb.push_back({i[AW-1:0], hw});
            send_byte(hw[15:8], v.gaps, 1'b0);
        end
        send_byte(v.bad_csum ? csum + 8'h01 : csum, v.gaps, 1'b0);
        @(negedge clock);
        byte_valid = 1'b0;
        check($sformatf("v%0d done", idx), done, v.exp_done);
        check($sformatf("v%0d error", idx), error, !v.exp_done);
        check($sformatf("v%0d cpu_reset", idx), cpu_reset, !v.exp_done);
        check($sformatf("v%0d byte_ready_end", idx), byte_ready, 0);
        check($sformatf("v%0d write_count", idx), writes_seen, v.n);
        check($sformatf("v%0d sb_empty", idx), sb.size(), 0);
        if (v.n > 0) check($sformatf("v%0d last_addr", idx), last_addr, v.n - 1);
    endtask

    vec_t vecs[8];

    initial begin
        //            n     fixed bad  gaps mid  done
        vecs[0] = '{2,    1,    0,   0,   0,   1};
        vecs[1] = '{2,    1,    1,   0,   0,   0};
        vecs[2] = '{2,    1,    0,   0,   0,   1};
        vecs[3] = '{0,    0,    0,   0,   0,   1};
        vecs[4] = '{2,    1,    0,   1,   1,   1};
        vecs[5] = '{7,    0,    0,   1,   0,   1};
        vecs[6] = '{5,    0,    1,   1,   1,   0};
        vecs[7] = '{1024, 0,    0,   0,   0,   1};

        #12;
        check("rst byte_ready", byte_ready, 0);
        check("rst wr_en", wr_en, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst wr_data", wr_data, 0);
        check("rst cpu_reset", cpu_reset, 1);
        check("rst done", done, 0);
        check("rst error", error, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_load(vecs[i], i);

        // Length 1025 exceeds memory depth.
        writes_seen = 0;
        pulse_start();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        @(negedge clock);
        byte_valid = 1'b0;
        check("ovf error", error, 1);
        check("ovf byte_ready", byte_ready, 0);
        check("ovf cpu_reset", cpu_reset, 1);
        repeat (2) @(posedge clock);
        check("ovf writes", writes_seen, 0);

        // Asynchronous reset while DATA_HI is pending.
        writes_seen = 0;
        pulse_start();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        #2 reset = 1'b1;
        byte_valid = 1'b0;
        #1;
        check("arst byte_ready", byte_ready, 0);
        check("arst wr_en", wr_en, 0);
        check("arst cpu_reset", cpu_reset, 1);
        check("arst done", done, 0);
        check("arst error", error, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        check("arst writes", writes_seen, 0);

        // Recovery from IDLE after reset.
        run_load(vecs[0], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
